// File: rtl/ram_handshake_mem.sv
// ram_handshake_mem: four-phase handshake word RAM with WAIT_STATES delay; byte_en write mask when RAM_BYTE_ENABLE_EN is defined
module ram_handshake_mem #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9,
  parameter int MEM_SIZE      = 512,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     Clock,
  input  logic                     Clear,
  input  logic                     read,
  input  logic                     write,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data_in,
`ifdef RAM_BYTE_ENABLE_EN
  input  logic [DATA_WIDTH/8-1:0]  byte_en,
`endif
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     complete,
  output logic                     busy,
  output logic                     error
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q, a;
  logic [DATA_WIDTH-1:0] din_q, d, wr_word;
  logic wr_q, bad_q, w, bad, acc, fire;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
`ifdef RAM_BYTE_ENABLE_EN
  logic [DATA_WIDTH/8-1:0] be_q, b;
`endif
  always_comb begin
    acc = state == IDLE && (read || write);
    a = acc ? address : addr_q;
    d = acc ? data_in : din_q;
    w = acc ? write : wr_q;
    bad = acc ? (read && write) || 32'(address) >= MEM_SIZE : bad_q;
    fire = acc ? WAIT_STATES == 0 : state == WAIT && cnt == 4'd1;
    state_n = fire ? DONE : acc ? WAIT : (state == DONE && !read && !write) ? IDLE : state;
`ifdef RAM_BYTE_ENABLE_EN
    b = acc ? byte_en : be_q;
    wr_word = mem[a];
    for (int j = 0; j < DATA_WIDTH / 8; j++)
      wr_word[8*j +: 8] = b[j] ? d[8*j +: 8] : wr_word[8*j +: 8];
`else
    wr_word = d;
`endif
  end
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= IDLE;
      cnt <= 4'd0;
      data_out <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        cnt <= 4'(WAIT_STATES);
        addr_q <= address;
        din_q <= data_in;
        wr_q <= write;
        bad_q <= bad;
        error <= bad;
`ifdef RAM_BYTE_ENABLE_EN
        be_q <= byte_en;
`endif
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !bad && !w) data_out <= mem[a];
    end
  end
  always_ff @(posedge Clock)
    if (!Clear && fire && !bad && w) mem[a] <= wr_word;
  assign complete = state == DONE;
  assign busy = state != IDLE;
endmodule
